// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - command FIFO plus sequencer for the accumulator, register bank and output port
module uart_cmd_ctrl #(
  parameter int DEPTH   = 4,
  parameter int MUL_CYC = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [3:0] rx_dado,
  input  logic [3:0] rx_instr,
  input  logic       out_ready,
  input  logic       clr_err,
  output logic [3:0] out_data,
  output logic       out_valid,
  output logic [3:0] acc,
  output logic       carry,
  output logic       busy,
  output logic       err_illegal,
  output logic       err_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = $clog2(MUL_CYC + 1);
  localparam logic [MW-1:0] MUL_LAST = MW'(MUL_CYC - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, OUT_WAIT} state_t;

  state_t         state, state_nx;
  logic [7:0]     fifo_mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;
  logic [3:0]     cmd_op, cmd_d;
  logic [3:0]     regs [4];
  logic [7:0]     mul_prod, mul_mcand, mul_step;
  logic [3:0]     mul_mplier;
  logic [MW-1:0]  mul_cnt;
  logic [4:0]     add_res, sub_res;
  logic           pop, push, full, drop, illegal;

  assign full     = (count == CW'(DEPTH));
  assign pop      = (state == IDLE) && (count != '0);
  assign push     = rx_valid && (!full || pop);
  assign drop     = rx_valid && !push;
  assign illegal  = (state == EXEC) && (cmd_op >= 4'hC);
  assign busy     = (state != IDLE) || (count != '0);
  assign add_res  = {1'b0, acc} + {1'b0, cmd_d};
  assign sub_res  = {1'b0, acc} - {1'b0, cmd_d};
  assign mul_step = mul_prod + (mul_mplier[0] ? mul_mcand : 8'd0);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (pop) state_nx = EXEC;
      EXEC: begin
        if (cmd_op == 4'h9)      state_nx = MUL;
        else if (cmd_op == 4'hB) state_nx = OUT_WAIT;
        else                     state_nx = IDLE;
      end
      MUL:      if (mul_cnt == MUL_LAST) state_nx = IDLE;
      OUT_WAIT: if (out_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Storage array carries no reset; count/pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wptr] <= {rx_instr, rx_dado};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      cmd_op      <= 4'd0;
      cmd_d       <= 4'd0;
      acc         <= 4'd0;
      carry       <= 1'b0;
      out_data    <= 4'd0;
      out_valid   <= 1'b0;
      err_illegal <= 1'b0;
      err_ovf     <= 1'b0;
      mul_prod    <= 8'd0;
      mul_mcand   <= 8'd0;
      mul_mplier  <= 4'd0;
      mul_cnt     <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr   <= rptr + 1'b1;
        cmd_op <= fifo_mem[rptr][7:4];
        cmd_d  <= fifo_mem[rptr][3:0];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        EXEC: begin
          case (cmd_op)
            4'h1: acc <= cmd_d;
            4'h2: begin acc <= add_res[3:0]; carry <= add_res[4]; end
            4'h3: begin acc <= sub_res[3:0]; carry <= sub_res[4]; end
            4'h4: acc <= acc & cmd_d;
            4'h5: acc <= acc | cmd_d;
            4'h6: acc <= acc ^ cmd_d;
            4'h7: regs[cmd_d[1:0]] <= acc;
            4'h8: acc <= regs[cmd_d[1:0]];
            4'h9: begin
              mul_prod   <= 8'd0;
              mul_mcand  <= {4'd0, acc};
              mul_mplier <= cmd_d;
              mul_cnt    <= '0;
            end
            4'hA: begin acc <= 4'd0; carry <= 1'b0; end
            4'hB: begin out_data <= acc; out_valid <= 1'b1; end
            default: ;
          endcase
        end
        MUL: begin
          mul_prod   <= mul_step;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + 1'b1;
          if (mul_cnt == MUL_LAST) begin
            acc   <= mul_step[3:0];
            carry <= |mul_step[7:4];
          end
        end
        OUT_WAIT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase

      // A fresh error outranks a simultaneous clear.
      if (drop)         err_ovf <= 1'b1;
      else if (clr_err) err_ovf <= 1'b0;
      if (illegal)      err_illegal <= 1'b1;
      else if (clr_err) err_illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

  logic       clock = 1'b0;
  logic       reset, rx_valid, out_ready, clr_err;
  logic [3:0] rx_dado, rx_instr;
  logic [3:0] out_data, acc;
  logic       out_valid, carry, busy, err_illegal, err_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid_cyc = 0;
  logic [3:0] last_out = 4'd0;
  int base;

  uart_cmd_ctrl #(.DEPTH(4), .MUL_CYC(4)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_dado(rx_dado),
    .rx_instr(rx_instr), .out_ready(out_ready), .clr_err(clr_err),
    .out_data(out_data), .out_valid(out_valid), .acc(acc), .carry(carry),
    .busy(busy), .err_illegal(err_illegal), .err_ovf(err_ovf)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (out_valid) n_valid_cyc++;
    if (out_valid && out_ready) last_out = out_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] d);
    rx_instr = op;
    rx_dado  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!busy && !out_valid) break;
    end
    check(tag, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_dado = 4'd0; rx_instr = 4'd0;
    out_ready = 1'b1; clr_err = 1'b0;
    tick(); tick();
    check("rst_acc", acc, 4'h0);
    check("rst_carry", carry, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_oval", out_valid, 1'b0);
    check("rst_odata", out_data, 4'h0);
    check("rst_errs", {err_illegal, err_ovf}, 2'b00);
    reset = 1'b0;
    tick();

    // 1: latency, then LOAD 5 / ADD 3 / OUT
    send(4'h1, 4'h5);
    tick();
    check("lat_k1_acc", acc, 4'h0);
    tick();
    check("lat_k2_acc", acc, 4'h5);
    base = n_valid_cyc;
    send(4'h2, 4'h3);
    send(4'hB, 4'h0);
    wait_idle("t1_idle");
    check("t1_acc", acc, 4'h8);
    check("t1_out", last_out, 4'h8);
    check("t1_vcyc", n_valid_cyc - base, 1);
    check("t1_carry", carry, 1'b0);

    // 2: ADD carry, SUB borrow
    send(4'h1, 4'hF);
    send(4'h2, 4'h2);
    wait_idle("t2_idle_a");
    check("t2_add_acc", acc, 4'h1);
    check("t2_add_c", carry, 1'b1);
    send(4'h3, 4'h3);
    wait_idle("t2_idle_b");
    check("t2_sub_acc", acc, 4'hE);
    check("t2_sub_c", carry, 1'b1);

    // 3: MUL timing and result
    send(4'hA, 4'h0);
    send(4'h1, 4'h3);
    wait_idle("t3_idle_a");
    check("t3_pre_acc", acc, 4'h3);
    check("t3_pre_c", carry, 1'b0);
    send(4'h9, 4'h6);
    for (int i = 0; i < 5; i++) tick();
    check("t3_mul_hold", acc, 4'h3);
    check("t3_mul_busy", busy, 1'b1);
    tick();
    check("t3_mul_acc", acc, 4'h2);
    check("t3_mul_c", carry, 1'b1);
    wait_idle("t3_idle_b");

    // 4: register bank round trip
    send(4'h1, 4'h7);
    send(4'h7, 4'h2);
    send(4'hA, 4'h0);
    send(4'h8, 4'h2);
    send(4'hB, 4'h0);
    wait_idle("t4_idle");
    check("t4_out", last_out, 4'h7);
    check("t4_acc", acc, 4'h7);

    // 5: stalled output, FIFO overflow, ordered drain, clear
    out_ready = 1'b0;
    send(4'hB, 4'h0);
    for (int i = 0; i < 10; i++) begin
      if (out_valid) break;
      tick();
    end
    check("t5_oval", out_valid, 1'b1);
    send(4'h1, 4'h1);
    send(4'h2, 4'h2);
    send(4'h2, 4'h3);
    send(4'hB, 4'h0);
    send(4'h2, 4'h9);
    check("t5_ovf", err_ovf, 1'b1);
    check("t5_hold_v", out_valid, 1'b1);
    check("t5_hold_d", out_data, 4'h7);
    check("t5_busy", busy, 1'b1);
    out_ready = 1'b1;
    wait_idle("t5_idle");
    check("t5_out", last_out, 4'h6);
    check("t5_acc", acc, 4'h6);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t5_clr", err_ovf, 1'b0);

    // 6: illegal opcode, then reset during MUL with a queued frame
    send(4'hE, 4'h5);
    wait_idle("t6_idle");
    check("t6_ill", err_illegal, 1'b1);
    check("t6_acc", acc, 4'h6);
    send(4'h9, 4'h3);
    send(4'h1, 4'h9);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("t6_rst_acc", acc, 4'h0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_carry", carry, 1'b0);
    check("t6_rst_errs", {err_illegal, err_ovf}, 2'b00);
    check("t6_rst_oval", out_valid, 1'b0);
    reset = 1'b0;
    tick(); tick(); tick();
    check("t6_post_acc", acc, 4'h0);
    check("t6_post_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
